chip8_scanout: RTL and testbench

- Downstream consumer of the CPU's 2048-word vram (64x32, one 32-bit word per pixel).
- On each frame request, walks vram in row-major order and emits a pixel stream over a valid/ready handshake, with optional integer upscaling.
- Replaces the combinational draw path with a paced, back-pressurable display feed.
- Raises busy for the whole frame so the CPU can stall DRW/CLS and avoid tearing.

---
 rtl/chip8_scanout.sv | 104 ++++++++++
 tb/tb_chip8_scanout.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_scanout.sv
// Frame scanout for the CHIP-8 framebuffer: walks vram row-major and emits a
// back-pressurable pixel stream with integer upscaling in both axes.
module chip8_scanout #(
  parameter int          WIDTH     = 64,
  parameter int          HEIGHT    = 32,
  parameter int          SCALE     = 1,
  parameter logic [31:0] ON_COLOR  = 32'hFFFFFFFF,
  parameter logic [31:0] OFF_COLOR = 32'h00000000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_req,
  output logic        busy,
  output logic        frame_done,
  output logic        vram_rd_en,
  output logic [10:0] vram_addr,
  input  logic [31:0] vram_data,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, PRESENT} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] src_col;
  logic [RW-1:0] src_row;
  logic [2:0]    hrep, vrep;
  logic          accept, last_h, last_col, last_v, last_row, last_beat;

  assign accept    = (state == PRESENT) && pix_ready;
  assign last_h    = (hrep == 3'(SCALE - 1));
  assign last_v    = (vrep == 3'(SCALE - 1));
  assign last_col  = (src_col == CW'(WIDTH - 1));
  assign last_row  = (src_row == RW'(HEIGHT - 1));
  assign last_beat = last_h && last_col && last_v && last_row;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_req) state_nxt = FETCH;
      FETCH:   state_nxt = WAIT;
      WAIT:    state_nxt = PRESENT;
      PRESENT: begin
        // horizontal repeats reuse the captured pixel; only a new column refetches
        if (accept && last_h) state_nxt = last_beat ? IDLE : FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign vram_rd_en = (state == FETCH);
  assign pix_valid  = (state == PRESENT);
  assign vram_addr  = 11'(src_row) * 11'(WIDTH) + 11'(src_col);
  assign pix_sof    = pix_valid && (src_row == '0) && (src_col == '0) &&
                      (hrep == '0) && (vrep == '0);
  assign pix_eol    = pix_valid && last_col && last_h;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      src_col    <= '0;
      src_row    <= '0;
      hrep       <= '0;
      vrep       <= '0;
      pix_data   <= OFF_COLOR;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last_beat;
      if (state == IDLE && frame_req) begin
        src_col <= '0;
        src_row <= '0;
        hrep    <= '0;
        vrep    <= '0;
      end
      if (state == WAIT) pix_data <= (vram_data != 32'd0) ? ON_COLOR : OFF_COLOR;
      if (accept) begin
        if (!last_h) hrep <= hrep + 3'd1;
        else begin
          hrep <= '0;
          if (!last_col) src_col <= src_col + 1'b1;
          else begin
            src_col <= '0;
            // vertical repeats rescan the same source row, refetching it
            if (!last_v) vrep <= vrep + 3'd1;
            else begin
              vrep    <= '0;
              src_row <= last_row ? '0 : src_row + 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_chip8_scanout.sv
// Scoreboard bench for chip8_scanout: expected beats are queued at frame start
// and popped by per-instance monitors on every accepted beat.
module tb_chip8_scanout;
  localparam logic [31:0] ON  = 32'hFFFFFFFF;
  localparam logic [31:0] OFF = 32'h00000000;

  typedef struct packed {logic [31:0] d; logic sof; logic eol;} beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_in = 1'b1;
  logic fr1 = 1'b0, fr2 = 1'b0;
  logic rdy1 = 1'b1, rdy2 = 1'b1;
  logic busy1, done1, rd1, valid1, sof1, eol1;
  logic busy2, done2, rd2, valid2, sof2, eol2;
  logic [10:0] addr1, addr2;
  logic [31:0] vd1 = '0, vd2 = '0, pd1, pd2;
  logic [31:0] mem1 [2048];
  logic [31:0] mem2 [2048];

  chip8_scanout #(.SCALE(1)) dut1 (
    .clk_in(clk), .rst_in(rst_in), .frame_req(fr1), .busy(busy1), .frame_done(done1),
    .vram_rd_en(rd1), .vram_addr(addr1), .vram_data(vd1), .pix_data(pd1),
    .pix_valid(valid1), .pix_ready(rdy1), .pix_sof(sof1), .pix_eol(eol1));

  chip8_scanout #(.SCALE(2)) dut2 (
    .clk_in(clk), .rst_in(rst_in), .frame_req(fr2), .busy(busy2), .frame_done(done2),
    .vram_rd_en(rd2), .vram_addr(addr2), .vram_data(vd2), .pix_data(pd2),
    .pix_valid(valid2), .pix_ready(rdy2), .pix_sof(sof2), .pix_eol(eol2));

  int total = 0, bad = 0, cyc = 0;
  int beats1, eols1, dones1, reads1, last_cyc1, done_cyc1;
  int beats2, eols2, dones2, reads2;
  bit bp = 1'b0;
  beat_t q1[$];
  beat_t q2[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // synchronous vram models: data one cycle after the read strobe
  initial forever begin
    @(posedge clk);
    if (rd1) vd1 <= mem1[addr1];
    if (rd2) vd2 <= mem2[addr2];
  end

  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(posedge clk); #1;
    rdy1 = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  // monitor for the SCALE=1 instance
  initial begin
    bit    stalled = 1'b0;
    beat_t held, got, exp;
    forever begin
      @(negedge clk);
      got = '{d: pd1, sof: sof1, eol: eol1};
      if (rd1) reads1++;
      if (done1) begin
        dones1++; done_cyc1 = cyc;
        chk("busy_at_done", busy1, 0);
      end
      if (stalled) begin
        chk("stall_valid_held", valid1, 1);
        chk("stall_beat_held", got, held);
        chk("no_read_in_stall", rd1, 0);
      end
      stalled = valid1 && !rdy1;
      held    = got;
      if (valid1 && rdy1) begin
        if (q1.size() == 0) chk("unexpected_beat1", beats1, 32'hFFFF);
        else begin
          exp = q1.pop_front();
          chk($sformatf("beat1[%0d]", beats1), got, exp);
        end
        chk("busy_in_beat", busy1, 1);
        beats1++;
        if (eol1) eols1++;
        last_cyc1 = cyc;
      end
    end
  end

  // monitor for the SCALE=2 instance
  initial begin
    beat_t got, exp;
    forever begin
      @(negedge clk);
      if (rd2) reads2++;
      if (done2) dones2++;
      if (valid2 && rdy2) begin
        got = '{d: pd2, sof: sof2, eol: eol2};
        if (q2.size() == 0) chk("unexpected_beat2", beats2, 32'hFFFF);
        else begin
          exp = q2.pop_front();
          chk($sformatf("beat2[%0d]", beats2), got, exp);
        end
        beats2++;
        if (eol2) eols2++;
      end
    end
  end

  task automatic push_frame1();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++)
        q1.push_back('{d: (mem1[r*64+c] != 0) ? ON : OFF, sof: (r == 0 && c == 0), eol: (c == 63)});
  endtask

  task automatic clr1();
    beats1 = 0; eols1 = 0; dones1 = 0; reads1 = 0; last_cyc1 = -10; done_cyc1 = -20;
  endtask

  // frame_req is raised just after an edge and sampled on the next one
  task automatic pulse1();
    @(posedge clk); #1 fr1 = 1'b1;
    @(posedge clk); #1 fr1 = 1'b0;
  endtask

  task automatic wait_done1(input string name);
    int n = 0;
    while (dones1 == 0 && n < 40000) begin @(posedge clk); n++; end
    if (dones1 == 0) chk({name, "_timeout"}, 0, 1);
    repeat (10) @(posedge clk);
  endtask

  task automatic check_frame1(input string name);
    chk({name, "_beats"}, beats1, 2048);
    chk({name, "_eols"}, eols1, 32);
    chk({name, "_dones"}, dones1, 1);
    chk({name, "_reads"}, reads1, 2048);
    chk({name, "_done_lat"}, done_cyc1 - last_cyc1, 1);
    chk({name, "_sb_empty"}, q1.size(), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2048; i++) begin mem1[i] = '0; mem2[i] = '0; end
    mem1[0] = 32'hFFFFFFFF; mem1[2047] = 32'h00000001;
    mem2[65] = 32'hFFFFFFFF;
    clr1();
    beats2 = 0; eols2 = 0; dones2 = 0; reads2 = 0;

    // reset asserted with a frame request: reset must win
    fr1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b0; fr1 = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_valid", valid1, 0);
    chk("rst_rd_en", rd1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_data", pd1, OFF);
    chk("rst_sof_eol", {sof1, eol1, done1}, 0);

    // frame 1: latency and content
    clr1(); push_frame1();
    pulse1();
    @(negedge clk);
    chk("lat_c1_rd_en", rd1, 1);
    chk("lat_c1_addr", addr1, 0);
    chk("lat_c1_busy", busy1, 1);
    chk("lat_c1_valid", valid1, 0);
    @(negedge clk);
    chk("lat_c2_valid", valid1, 0);
    @(negedge clk);
    chk("lat_c3_valid", valid1, 1);
    wait_done1("f1");
    check_frame1("f1");

    // back-pressure: same sequence with ~30% ready
    clr1(); push_frame1(); bp = 1'b1;
    pulse1();
    wait_done1("bp");
    bp = 1'b0;
    check_frame1("bp");

    // frame_req during an active frame is ignored
    clr1(); push_frame1();
    pulse1();
    n = 0;
    while (beats1 < 100 && n < 5000) begin @(posedge clk); n++; end
    #1 fr1 = 1'b1;
    @(posedge clk); #1 fr1 = 1'b0;
    wait_done1("ign");
    repeat (20) @(posedge clk);
    check_frame1("ign");
    chk("ign_idle_after", {busy1, valid1}, 0);

    // reset mid-frame aborts without frame_done, then a clean restart
    clr1(); push_frame1();
    pulse1();
    n = 0;
    while (beats1 < 500 && n < 5000) begin @(posedge clk); n++; end
    #1 rst_in = 1'b1;
    @(posedge clk); #1 rst_in = 1'b0;
    @(negedge clk);
    chk("abort_valid", valid1, 0);
    chk("abort_busy", busy1, 0);
    chk("abort_data", pd1, OFF);
    q1.delete();
    repeat (20) @(posedge clk);
    chk("abort_no_done", dones1, 0);
    clr1(); push_frame1();
    pulse1();
    wait_done1("restart");
    check_frame1("restart");

    // SCALE=2 frame
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 128; c++)
        q2.push_back('{d: (mem2[(r/2)*64 + c/2] != 0) ? ON : OFF,
                       sof: (r == 0 && c == 0), eol: (c == 127)});
    @(posedge clk); #1 fr2 = 1'b1;
    @(posedge clk); #1 fr2 = 1'b0;
    n = 0;
    while (dones2 == 0 && n < 40000) begin @(posedge clk); n++; end
    if (dones2 == 0) chk("s2_timeout", 0, 1);
    repeat (10) @(posedge clk);
    chk("s2_beats", beats2, 8192);
    chk("s2_reads", reads2, 4096);
    chk("s2_eols", eols2, 64);
    chk("s2_dones", dones2, 1);
    chk("s2_sb_empty", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
